stack_controller: RTL and testbench

STACK_CONTROLLER -- requirements
Module: stack_controller

---
 rtl/stacker_pkg.sv | 25 ++
 rtl/block_overlap.sv | 28 ++
 rtl/stack_controller.sv | 202 ++++++++++++++++++++
 tb/tb_stack_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stacker_pkg.sv
// Shared constants and types for the stacking game controller.
package stacker_pkg;

   localparam int CELL_W        = 4;
   localparam int SUM_W         = CELL_W + 1;

   localparam int COLS_DEF      = 16;
   localparam int ROWS_DEF      = 12;
   localparam int INIT_SIZE_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_MOVE      = 3'd1,
      ST_CHECK     = 3'd2,
      ST_PLACE     = 3'd3,
      ST_GAME_OVER = 3'd4,
      ST_WIN       = 3'd5
   } state_t;

   typedef enum logic {
      DIR_RIGHT = 1'b0,
      DIR_LEFT  = 1'b1
   } dir_t;

endpackage

// File: rtl/block_overlap.sv
// Overlap of two horizontal cell spans given as (x, size) pairs.
module block_overlap
   import stacker_pkg::*;
(
   input  logic [CELL_W-1:0] a_x,
   input  logic [CELL_W-1:0] a_size,
   input  logic [CELL_W-1:0] b_x,
   input  logic [CELL_W-1:0] b_size,
   output logic [CELL_W-1:0] lo,
   output logic [CELL_W-1:0] size,
   output logic              hit
);

   logic [SUM_W-1:0] a_end;
   logic [SUM_W-1:0] b_end;
   logic [SUM_W-1:0] hi;

   // Span ends need one extra bit: x + size can reach COLS.
   always_comb begin
      a_end = {1'b0, a_x} + {1'b0, a_size};
      b_end = {1'b0, b_x} + {1'b0, b_size};
      lo    = (a_x > b_x) ? a_x : b_x;
      hi    = (a_end < b_end) ? a_end : b_end;
      hit   = hi > {1'b0, lo};
      size  = hi[CELL_W-1:0] - lo;
   end

endmodule

// File: rtl/stack_controller.sv
// Stacking game controller: moving block, stop/trim against previous row.
//
// state        | meaning
// ST_IDLE      | after reset, waiting for start
// ST_MOVE      | block bounces on tick, waiting for stop edge
// ST_CHECK     | trim block against previous row (one cycle)
// ST_PLACE     | commit row, pulse place_valid (one cycle)
// ST_GAME_OVER | no overlap, waiting for start
// ST_WIN       | last row placed, waiting for start
module stack_controller
   import stacker_pkg::*;
#(
   parameter int COLS      = COLS_DEF,
   parameter int ROWS      = ROWS_DEF,
   parameter int INIT_SIZE = INIT_SIZE_DEF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              tick,
   input  logic              stop_btn,
   output logic [CELL_W-1:0] blk_x,
   output logic [CELL_W-1:0] blk_size,
   output logic [CELL_W-1:0] row,
   output logic              place_valid,
   output logic [CELL_W-1:0] placed_x,
   output logic [CELL_W-1:0] placed_size,
   output logic              game_over,
   output logic              win
);

   localparam logic [CELL_W-1:0] INIT_SZ  = CELL_W'(INIT_SIZE);
   localparam logic [CELL_W-1:0] LAST_ROW = CELL_W'(ROWS - 1);
   localparam logic [SUM_W-1:0]  COLS_W   = SUM_W'(COLS);

   state_t            state_q, state_d;
   dir_t              dir_q, dir_d;
   logic [CELL_W-1:0] row_q, row_d;
   logic [CELL_W-1:0] blk_x_q, blk_x_d;
   logic [CELL_W-1:0] blk_size_q, blk_size_d;
   logic [CELL_W-1:0] prev_x_q, prev_x_d;
   logic [CELL_W-1:0] prev_size_q, prev_size_d;
   logic [CELL_W-1:0] placed_x_q, placed_x_d;
   logic [CELL_W-1:0] placed_size_q, placed_size_d;
   logic              place_valid_q, place_valid_d;
   logic              game_over_q, game_over_d;
   logic              win_q, win_d;
   logic              stop_prev_q, stop_prev_d;

   logic              stop_edge;
   logic              full_width;
   logic [SUM_W-1:0]  blk_end;
   logic [CELL_W-1:0] ov_lo;
   logic [CELL_W-1:0] ov_size;
   logic              ov_hit;

   block_overlap u_overlap (
      .a_x    (blk_x_q),
      .a_size (blk_size_q),
      .b_x    (prev_x_q),
      .b_size (prev_size_q),
      .lo     (ov_lo),
      .size   (ov_size),
      .hit    (ov_hit)
   );

   // Next-state and datapath updates; everything holds unless a state acts.
   always_comb begin
      state_d       = state_q;
      dir_d         = dir_q;
      row_d         = row_q;
      blk_x_d       = blk_x_q;
      blk_size_d    = blk_size_q;
      prev_x_d      = prev_x_q;
      prev_size_d   = prev_size_q;
      placed_x_d    = placed_x_q;
      placed_size_d = placed_size_q;
      place_valid_d = 1'b0;
      game_over_d   = game_over_q;
      win_d         = win_q;
      stop_prev_d   = stop_btn;

      stop_edge  = stop_btn & ~stop_prev_q;
      blk_end    = {1'b0, blk_x_q} + {1'b0, blk_size_q};
      full_width = ({1'b0, blk_size_q} == COLS_W);

      case (state_q)
         ST_IDLE, ST_GAME_OVER, ST_WIN: begin
            if (start) begin
               row_d       = '0;
               blk_x_d     = '0;
               blk_size_d  = INIT_SZ;
               dir_d       = DIR_RIGHT;
               game_over_d = 1'b0;
               win_d       = 1'b0;
               state_d     = ST_MOVE;
            end
         end

         ST_MOVE: begin
            // A stop edge wins over a simultaneous tick so the block freezes where seen.
            if (stop_edge) begin
               state_d = ST_CHECK;
            end else if (tick && !full_width) begin
               if (dir_q == DIR_RIGHT) begin
                  if (blk_end == COLS_W) begin
                     dir_d   = DIR_LEFT;
                     blk_x_d = blk_x_q - CELL_W'(1);
                  end else begin
                     blk_x_d = blk_x_q + CELL_W'(1);
                  end
               end else begin
                  if (blk_x_q == '0) begin
                     dir_d   = DIR_RIGHT;
                     blk_x_d = blk_x_q + CELL_W'(1);
                  end else begin
                     blk_x_d = blk_x_q - CELL_W'(1);
                  end
               end
            end
         end

         ST_CHECK: begin
            if (row_q == '0) begin
               placed_x_d    = blk_x_q;
               placed_size_d = blk_size_q;
               place_valid_d = 1'b1;
               state_d       = ST_PLACE;
            end else if (ov_hit) begin
               blk_x_d       = ov_lo;
               blk_size_d    = ov_size;
               placed_x_d    = ov_lo;
               placed_size_d = ov_size;
               place_valid_d = 1'b1;
               state_d       = ST_PLACE;
            end else begin
               game_over_d = 1'b1;
               state_d     = ST_GAME_OVER;
            end
         end

         ST_PLACE: begin
            prev_x_d    = blk_x_q;
            prev_size_d = blk_size_q;
            if (row_q == LAST_ROW) begin
               win_d   = 1'b1;
               state_d = ST_WIN;
            end else begin
               row_d   = row_q + CELL_W'(1);
               blk_x_d = '0;
               dir_d   = DIR_RIGHT;
               state_d = ST_MOVE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= ST_IDLE;
         dir_q         <= DIR_RIGHT;
         row_q         <= '0;
         blk_x_q       <= '0;
         blk_size_q    <= INIT_SZ;
         prev_x_q      <= '0;
         prev_size_q   <= '0;
         placed_x_q    <= '0;
         placed_size_q <= '0;
         place_valid_q <= 1'b0;
         game_over_q   <= 1'b0;
         win_q         <= 1'b0;
         stop_prev_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         dir_q         <= dir_d;
         row_q         <= row_d;
         blk_x_q       <= blk_x_d;
         blk_size_q    <= blk_size_d;
         prev_x_q      <= prev_x_d;
         prev_size_q   <= prev_size_d;
         placed_x_q    <= placed_x_d;
         placed_size_q <= placed_size_d;
         place_valid_q <= place_valid_d;
         game_over_q   <= game_over_d;
         win_q         <= win_d;
         stop_prev_q   <= stop_prev_d;
      end
   end

   assign blk_x       = blk_x_q;
   assign blk_size    = blk_size_q;
   assign row         = row_q;
   assign place_valid = place_valid_q;
   assign placed_x    = placed_x_q;
   assign placed_size = placed_size_q;
   assign game_over   = game_over_q;
   assign win         = win_q;

endmodule

// File: tb/tb_stack_controller.sv
// Bench for stack_controller: directed game scenarios plus random play
// against a behavioural model of the game rules.
module tb_stack_controller;

   localparam int M_COLS = 16;
   localparam int M_ROWS = 12;
   localparam int M_INIT = 4;

   logic clk = 1'b0;
   logic resetn = 1'b1;
   logic start = 1'b0;
   logic tick = 1'b0;
   logic stop_btn = 1'b0;

   logic [3:0] d_x, d_size, d_row, d_px, d_psize;
   logic       d_pv, d_go, d_win;
   logic [3:0] w_x, w_size, w_row, w_px, w_psize;
   logic       w_pv, w_go, w_win;
   logic [3:0] f_x, f_size, f_row, f_px, f_psize;
   logic       f_pv, f_go, f_win;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   stack_controller u_dut (
      .clk(clk), .resetn(resetn), .start(start), .tick(tick), .stop_btn(stop_btn),
      .blk_x(d_x), .blk_size(d_size), .row(d_row), .place_valid(d_pv),
      .placed_x(d_px), .placed_size(d_psize), .game_over(d_go), .win(d_win)
   );

   // Two-row game for the win check.
   stack_controller #(.ROWS(2)) u_dut_r2 (
      .clk(clk), .resetn(resetn), .start(start), .tick(tick), .stop_btn(stop_btn),
      .blk_x(w_x), .blk_size(w_size), .row(w_row), .place_valid(w_pv),
      .placed_x(w_px), .placed_size(w_psize), .game_over(w_go), .win(w_win)
   );

   // Block as wide as the field: must never move.
   stack_controller #(.COLS(4), .INIT_SIZE(4)) u_dut_full (
      .clk(clk), .resetn(resetn), .start(start), .tick(tick), .stop_btn(stop_btn),
      .blk_x(f_x), .blk_size(f_size), .row(f_row), .place_valid(f_pv),
      .placed_x(f_px), .placed_size(f_psize), .game_over(f_go), .win(f_win)
   );

   // Behavioural model: phase 0 waiting, 1 moving, 2 judging, 3 placing, 4 lost, 5 won.
   int m_phase, m_row, m_x, m_size, m_step, m_prev_x, m_prev_size;
   int m_pv, m_plx, m_pls, m_go, m_win;
   bit m_last_stop;

   task automatic model_reset();
      m_phase = 0; m_row = 0; m_x = 0; m_size = M_INIT; m_step = 1;
      m_prev_x = 0; m_prev_size = 0; m_pv = 0; m_plx = 0; m_pls = 0;
      m_go = 0; m_win = 0; m_last_stop = 1'b0;
   endtask

   task automatic model_clock();
      int lo, hi;
      bit pressed;
      pressed     = stop_btn && !m_last_stop;
      m_last_stop = stop_btn;
      m_pv        = 0;
      case (m_phase)
         0, 4, 5: if (start) begin
            m_row = 0; m_x = 0; m_size = M_INIT; m_step = 1;
            m_go = 0; m_win = 0; m_phase = 1;
         end
         1: begin
            if (pressed) m_phase = 2;
            else if (tick && m_size != M_COLS) begin
               if (m_step > 0 && m_x + m_size == M_COLS) m_step = -1;
               else if (m_step < 0 && m_x == 0) m_step = 1;
               m_x = m_x + m_step;
            end
         end
         2: begin
            if (m_row == 0) begin
               lo = m_x; hi = m_x + m_size;
            end else begin
               lo = (m_x > m_prev_x) ? m_x : m_prev_x;
               hi = (m_x + m_size < m_prev_x + m_prev_size) ? m_x + m_size
                                                             : m_prev_x + m_prev_size;
            end
            if (hi > lo) begin
               m_x = lo; m_size = hi - lo;
               m_pv = 1; m_plx = lo; m_pls = hi - lo; m_phase = 3;
            end else begin
               m_go = 1; m_phase = 4;
            end
         end
         3: begin
            m_prev_x = m_x; m_prev_size = m_size;
            if (m_row == M_ROWS - 1) begin
               m_win = 1; m_phase = 5;
            end else begin
               m_row = m_row + 1; m_x = 0; m_step = 1; m_phase = 1;
            end
         end
         default: m_phase = 0;
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("blk_x", 32'(d_x), m_x);
      chk("blk_size", 32'(d_size), m_size);
      chk("row", 32'(d_row), m_row);
      chk("place_valid", 32'(d_pv), m_pv);
      chk("game_over", 32'(d_go), m_go);
      chk("win", 32'(d_win), m_win);
      if (m_pv != 0) begin
         chk("placed_x", 32'(d_px), m_plx);
         chk("placed_size", 32'(d_psize), m_pls);
      end
   endtask

   task automatic step(input logic t, input logic s, input logic st);
      tick = t; stop_btn = s; start = st;
      @(posedge clk);
      model_clock();
      #1;
      check_model();
   endtask

   task automatic check_reset_all(input string tag);
      chk({tag, "_x"}, 32'(d_x), 0);        chk({tag, "_size"}, 32'(d_size), 4);
      chk({tag, "_row"}, 32'(d_row), 0);    chk({tag, "_pv"}, 32'(d_pv), 0);
      chk({tag, "_go"}, 32'(d_go), 0);      chk({tag, "_win"}, 32'(d_win), 0);
      chk({tag, "_r2"}, {w_x, w_size, w_row, w_pv, w_go, w_win}, {4'd0, 4'd4, 4'd0, 3'd0});
      chk({tag, "_fw"}, {f_x, f_size, f_row, f_pv, f_go, f_win}, {4'd0, 4'd4, 4'd0, 3'd0});
      chk({tag, "_placed"}, {d_px, d_psize, w_px, w_psize, f_px, f_psize}, 24'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      #1 resetn = 1'b0;
      #1 check_reset_all("reset");
      @(posedge clk); #1;
      resetn = 1'b1;

      // Game 1: stop with no ticks on row 0.
      step(0, 0, 1);
      chk("start_row", 32'(d_row), 0);
      chk("start_size", 32'(d_size), 4);
      step(0, 1, 0);
      chk("no_pulse_yet", 32'(d_pv), 0);
      step(0, 1, 0);
      chk("lat2_pv", 32'(d_pv), 1);
      chk("row0_placed", {d_px, d_psize}, {4'd0, 4'd4});
      step(0, 0, 0);
      chk("row1_row", 32'(d_row), 1);
      chk("row1_x", 32'(d_x), 0);
      chk("r2_not_won", 32'(w_win), 0);

      // Row 1: two cells right of prev 0/4.
      repeat (2) step(1, 0, 0);
      step(0, 1, 0);
      step(0, 0, 0);
      chk("trim_placed", {d_px, d_psize}, {4'd2, 4'd2});
      step(0, 0, 0);
      chk("r2_win", 32'(w_win), 1);

      // Row 2: tick and stop edge together at x=3, stop then held.
      repeat (3) step(1, 0, 0);
      step(1, 1, 0);
      chk("tick_ignored_x", 32'(d_x), 3);
      step(1, 1, 0);
      chk("tick_stop_placed", {d_px, d_psize}, {4'd3, 4'd1});
      step(1, 1, 0);
      repeat (4) step(1, 1, 0);
      chk("held_stop_row", 32'(d_row), 3);
      chk("held_stop_x", 32'(d_x), 4);
      step(0, 0, 0);
      step(0, 0, 1);
      chk("start_ignored_row", 32'(d_row), 3);

      // Row 3: x=4 against prev 3/1 misses.
      step(0, 1, 0);
      step(0, 1, 0);
      chk("miss_go", 32'(d_go), 1);
      chk("miss_no_pv", 32'(d_pv), 0);
      step(0, 0, 0);
      chk("go_sticky", 32'(d_go), 1);

      // Game 2: bounce sweep on row 0.
      step(0, 0, 1);
      chk("restart_go", 32'(d_go), 0);
      chk("restart_row", 32'(d_row), 0);
      repeat (12) step(1, 0, 0);
      chk("sweep_right_end", 32'(d_x), 12);
      step(1, 0, 0);
      chk("sweep_flip", 32'(d_x), 11);
      chk("full_width_still", 32'(f_x), 0);
      repeat (11) step(1, 0, 0);
      chk("sweep_left_end", 32'(d_x), 0);
      step(1, 0, 0);
      chk("sweep_flip_left", 32'(d_x), 1);
      repeat (23) step(1, 0, 0);
      chk("sweep_back", 32'(d_x), 0);
      step(0, 1, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      repeat (5) step(1, 0, 0);
      step(0, 1, 0);
      step(0, 0, 0);
      chk("disjoint_go", 32'(d_go), 1);
      chk("disjoint_no_pv", 32'(d_pv), 0);
      step(0, 0, 1);
      chk("clear_go", 32'(d_go), 0);
      chk("clear_row", 32'(d_row), 0);

      // Game 3: perfect stacking to the top row.
      for (int r = 0; r < M_ROWS; r++) begin
         step(0, 1, 0);
         step(0, 0, 0);
         step(0, 0, 0);
      end
      chk("full_game_win", 32'(d_win), 1);
      step(0, 0, 0);
      chk("win_sticky", 32'(d_win), 1);

      // Random play.
      for (int i = 0; i < 3000; i++) begin
         logic s;
         s = ($urandom_range(0, 5) == 0) ? ~stop_btn : stop_btn;
         step(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 29) == 0));
      end

      // Asynchronous reset in the middle of MOVE.
      #3 resetn = 1'b0;
      model_reset();
      #1 check_reset_all("async1");
      #2 resetn = 1'b1;
      step(0, 0, 1);
      repeat (3) step(1, 0, 0);
      chk("pre_reset_x", 32'(d_x), 3);
      #3 resetn = 1'b0;
      model_reset();
      #1 check_reset_all("async_move");
      #2 resetn = 1'b1;
      step(1, 0, 0);
      chk("idle_tick_x", 32'(d_x), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
